// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: writes mepc/mcause/mstatus, then redirects.
// Optional vectored interrupt targets under `TRAP_VECTORED_EN.
module trap_ctrl #(
   parameter int CSR_AW = 12,
   parameter int XLEN   = 32
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              exc_req_i,
   input  logic [3:0]        exc_cause_i,
   input  logic [XLEN-1:0]   exc_pc_i,
   input  logic              irq_i,
   input  logic [XLEN-1:0]   int_pc_i,
   input  logic              mret_i,
   input  logic [XLEN-1:0]   mtvec_i,
   input  logic [XLEN-1:0]   mepc_i,
   input  logic [XLEN-1:0]   mstatus_i,
   input  logic [XLEN-1:0]   mie_i,
   input  logic              ex_csr_we_i,
   input  logic [CSR_AW-1:0] ex_csr_waddr_i,
   input  logic [XLEN-1:0]   ex_csr_wdata_i,
   output logic              csr_we_o,
   output logic [CSR_AW-1:0] csr_waddr_o,
   output logic [XLEN-1:0]   csr_wdata_o,
   output logic              hold_o,
   output logic              jump_o,
   output logic [XLEN-1:0]   jump_addr_o
);

   typedef enum logic [2:0] {
      IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, R_MSTATUS, JUMP
   } state_t;

   localparam logic [CSR_AW-1:0] A_MSTATUS = CSR_AW'(12'h300);
   localparam logic [CSR_AW-1:0] A_MEPC    = CSR_AW'(12'h341);
   localparam logic [CSR_AW-1:0] A_MCAUSE  = CSR_AW'(12'h342);

   state_t            r_state;
   state_t            w_next;
   logic [XLEN-1:0]   r_pc;
   logic [XLEN-1:0]   r_cause;
   logic              r_is_irq;
   logic              r_mret;

   logic              w_irq_pend;
   logic              w_idle;
   logic              w_acc_exc;
   logic              w_acc_irq;
   logic              w_acc_mret;
   logic              w_we;
   logic [CSR_AW-1:0] w_waddr;
   logic [XLEN-1:0]   w_wdata;
   logic              w_hold;
   logic              w_jump;
   logic [XLEN-1:0]   w_jaddr;
   logic [XLEN-1:0]   w_base;
   logic [XLEN-1:0]   w_trap_tgt;
   logic [XLEN-1:0]   w_ms_trap;
   logic [XLEN-1:0]   w_ms_mret;
   logic              w_unused;

   // an exe CSR write in flight defers the interrupt by a cycle
   assign w_irq_pend = irq_i & mstatus_i[3] & mie_i[11] & ~ex_csr_we_i;
   assign w_idle     = (r_state == IDLE);
   assign w_acc_exc  = w_idle & exc_req_i;
   assign w_acc_irq  = w_idle & ~exc_req_i & w_irq_pend;
   assign w_acc_mret = w_idle & ~exc_req_i & ~w_irq_pend & mret_i;

   assign w_base = {mtvec_i[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
   assign w_trap_tgt = (mtvec_i[1:0] == 2'b01 && r_is_irq) ?
                       w_base + {r_cause[XLEN-3:0], 2'b00} : w_base;
`else
   assign w_trap_tgt = w_base;
`endif

   assign w_unused = ^{mie_i, mtvec_i[1:0], r_is_irq, r_cause};

   always_comb begin
      w_ms_trap        = mstatus_i;
      w_ms_trap[7]     = mstatus_i[3];
      w_ms_trap[3]     = 1'b0;
      w_ms_trap[12:11] = 2'b11;
      w_ms_mret        = mstatus_i;
      w_ms_mret[3]     = mstatus_i[7];
      w_ms_mret[7]     = 1'b1;
      w_ms_mret[12:11] = 2'b11;
   end

   always_comb begin
      w_next  = r_state;
      w_we    = 1'b0;
      w_waddr = '0;
      w_wdata = '0;
      w_hold  = 1'b0;
      w_jump  = 1'b0;
      w_jaddr = '0;
      unique case (r_state)
         IDLE: begin
            w_we    = ex_csr_we_i;
            w_waddr = ex_csr_waddr_i;
            w_wdata = ex_csr_wdata_i;
            if (exc_req_i) begin
               w_we   = 1'b0;
               w_hold = 1'b1;
               w_next = W_MEPC;
            end else if (w_irq_pend) begin
               w_hold = 1'b1;
               w_next = W_MEPC;
            end else if (mret_i) begin
               w_hold = 1'b1;
               w_next = R_MSTATUS;
            end
         end
         W_MEPC: begin
            w_we    = 1'b1;
            w_waddr = A_MEPC;
            w_wdata = r_pc;
            w_hold  = 1'b1;
            w_next  = W_MCAUSE;
         end
         W_MCAUSE: begin
            w_we    = 1'b1;
            w_waddr = A_MCAUSE;
            w_wdata = r_cause;
            w_hold  = 1'b1;
            w_next  = W_MSTATUS;
         end
         W_MSTATUS: begin
            w_we    = 1'b1;
            w_waddr = A_MSTATUS;
            w_wdata = w_ms_trap;
            w_hold  = 1'b1;
            w_next  = JUMP;
         end
         R_MSTATUS: begin
            w_we    = 1'b1;
            w_waddr = A_MSTATUS;
            w_wdata = w_ms_mret;
            w_hold  = 1'b1;
            w_next  = JUMP;
         end
         JUMP: begin
            w_hold  = 1'b1;
            w_jump  = 1'b1;
            w_jaddr = r_mret ? mepc_i : w_trap_tgt;
            w_next  = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         r_state  <= IDLE;
         r_pc     <= '0;
         r_cause  <= '0;
         r_is_irq <= 1'b0;
         r_mret   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_acc_exc) begin
            r_pc     <= exc_pc_i;
            r_cause  <= XLEN'(exc_cause_i);
            r_is_irq <= 1'b0;
            r_mret   <= 1'b0;
         end else if (w_acc_irq) begin
            r_pc     <= int_pc_i;
            r_cause  <= {1'b1, (XLEN-1)'(11)};
            r_is_irq <= 1'b1;
            r_mret   <= 1'b0;
         end else if (w_acc_mret) begin
            r_mret   <= 1'b1;
         end
      end
   end

   // reset forces every output low, independent of state
   assign csr_we_o    = rst_n_i & w_we;
   assign csr_waddr_o = csr_we_o ? w_waddr : '0;
   assign csr_wdata_o = csr_we_o ? w_wdata : '0;
   assign hold_o      = rst_n_i & w_hold;
   assign jump_o      = rst_n_i & w_jump;
   assign jump_addr_o = jump_o ? w_jaddr : '0;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: IDLE vector table plus trap/mret sequences.
module tb_trap_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        exc_req;
   logic [3:0]  exc_cause;
   logic [31:0] exc_pc;
   logic        irq;
   logic [31:0] int_pc;
   logic        mret;
   logic [31:0] mtvec, mepc, mstatus, mie;
   logic        ex_we;
   logic [11:0] ex_wa;
   logic [31:0] ex_wd;
   logic        csr_we;
   logic [11:0] csr_wa;
   logic [31:0] csr_wd;
   logic        hold, jump;
   logic [31:0] jaddr;

   int total = 0;
   int bad   = 0;

   trap_ctrl #(.CSR_AW(12), .XLEN(32)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .exc_req_i(exc_req), .exc_cause_i(exc_cause), .exc_pc_i(exc_pc),
      .irq_i(irq), .int_pc_i(int_pc), .mret_i(mret),
      .mtvec_i(mtvec), .mepc_i(mepc), .mstatus_i(mstatus), .mie_i(mie),
      .ex_csr_we_i(ex_we), .ex_csr_waddr_i(ex_wa), .ex_csr_wdata_i(ex_wd),
      .csr_we_o(csr_we), .csr_waddr_o(csr_wa), .csr_wdata_o(csr_wd),
      .hold_o(hold), .jump_o(jump), .jump_addr_o(jaddr)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   typedef struct {
      logic        exc, irq, mret, we;
      logic [11:0] wa;
      logic [31:0] wd, ms, mie;
      logic        e_we;
      logic [11:0] e_wa;
      logic [31:0] e_wd;
      logic        e_hold;
   } vec_t;

   vec_t vecs[5];

   task automatic nxt();
      @(negedge clk);
   endtask

   task automatic quiet();
      exc_req = 1'b0;
      irq     = 1'b0;
      mret    = 1'b0;
      ex_we   = 1'b0;
      ex_wa   = '0;
      ex_wd   = '0;
   endtask

   task automatic chk(input string nm, input logic we,
                      input logic [11:0] wa, input logic [31:0] wd,
                      input logic h, input logic j,
                      input logic [31:0] ja);
      logic [78:0] act, exp;
      #1;
      act = {csr_we, csr_wa, csr_wd, hold, jump, jaddr};
      exp = {we, wa, wd, h, j, ja};
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got we=%b a=%h d=%h h=%b j=%b ja=%h want we=%b a=%h d=%h h=%b j=%b ja=%h",
                  nm, csr_we, csr_wa, csr_wd, hold, jump, jaddr,
                  we, wa, wd, h, j, ja);
      end
   endtask

   logic [31:0] vec_tgt;

   initial begin
      vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 12'h305, 32'h1234, 32'h8, 32'h800,
                  1'b1, 12'h305, 32'h1234, 1'b0};
      vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 12'h305, 32'hFF, 32'h8, 32'h800,
                  1'b0, 12'h000, 32'h0, 1'b0};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 12'h340, 32'h5, 32'h8, 32'h800,
                  1'b1, 12'h340, 32'h5, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 32'h0, 32'h0, 32'h800,
                  1'b0, 12'h000, 32'h0, 1'b0};
      vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 32'h0, 32'h8, 32'h0,
                  1'b0, 12'h000, 32'h0, 1'b0};

      quiet();
      rst_n = 1'b0;
      exc_cause = 4'd0; exc_pc = '0; int_pc = '0;
      mtvec = 32'h100; mepc = '0; mstatus = 32'h8; mie = 32'h800;

      // reset: outputs low even with requests present
      nxt();
      ex_we = 1'b1; ex_wa = 12'h305; ex_wd = 32'hABCD; exc_req = 1'b1;
      chk("reset", 0, 0, 0, 0, 0, 0);
      nxt();
      quiet();
      rst_n = 1'b1;
      chk("idle_after_reset", 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 5; i++) begin
         nxt();
         exc_req = vecs[i].exc; irq = vecs[i].irq; mret = vecs[i].mret;
         ex_we = vecs[i].we; ex_wa = vecs[i].wa; ex_wd = vecs[i].wd;
         mstatus = vecs[i].ms; mie = vecs[i].mie;
         chk($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_wa,
             vecs[i].e_wd, vecs[i].e_hold, 1'b0, 32'h0);
      end

      // exception
      nxt(); quiet();
      mtvec = 32'h100; mstatus = 32'h8; mie = 32'h800;
      nxt();
      exc_req = 1'b1; exc_cause = 4'd11; exc_pc = 32'h80;
      chk("exc_T", 0, 0, 0, 1, 0, 0);
      nxt(); quiet();
      chk("exc_mepc", 1, 12'h341, 32'h80, 1, 0, 0);
      nxt(); chk("exc_mcause", 1, 12'h342, 32'hB, 1, 0, 0);
      nxt(); chk("exc_mstatus", 1, 12'h300, 32'h1880, 1, 0, 0);
      nxt(); chk("exc_jump", 0, 0, 0, 1, 1, 32'h100);
      nxt(); chk("exc_idle", 0, 0, 0, 0, 0, 0);

      // interrupt, mtvec in vectored mode
`ifdef TRAP_VECTORED_EN
      vec_tgt = 32'h12C;
`else
      vec_tgt = 32'h100;
`endif
      mtvec = 32'h101; int_pc = 32'h44;
      irq = 1'b1;
      chk("irq_T", 0, 0, 0, 1, 0, 0);
      nxt(); irq = 1'b0;
      chk("irq_mepc", 1, 12'h341, 32'h44, 1, 0, 0);
      nxt(); chk("irq_mcause", 1, 12'h342, 32'h8000000B, 1, 0, 0);
      nxt(); chk("irq_mstatus", 1, 12'h300, 32'h1880, 1, 0, 0);
      nxt(); chk("irq_jump", 0, 0, 0, 1, 1, vec_tgt);
      nxt(); chk("irq_idle", 0, 0, 0, 0, 0, 0);

      // mret
      mtvec = 32'h100; mstatus = 32'h1880; mepc = 32'h84;
      mret = 1'b1;
      chk("mret_T", 0, 0, 0, 1, 0, 0);
      nxt(); mret = 1'b0;
      chk("mret_mstatus", 1, 12'h300, 32'h1888, 1, 0, 0);
      nxt(); chk("mret_jump", 0, 0, 0, 1, 1, 32'h84);
      nxt(); chk("mret_idle", 0, 0, 0, 0, 0, 0);

      // exception + irq + exe write together
      mstatus = 32'h8; mie = 32'h800; int_pc = 32'h300;
      exc_req = 1'b1; exc_cause = 4'd2; exc_pc = 32'h200;
      irq = 1'b1; ex_we = 1'b1; ex_wa = 12'h305; ex_wd = 32'hDEAD;
      chk("mix_T", 0, 0, 0, 1, 0, 0);
      nxt(); exc_req = 1'b0; ex_we = 1'b0; ex_wa = '0; ex_wd = '0;
      chk("mix_mepc", 1, 12'h341, 32'h200, 1, 0, 0);
      nxt(); chk("mix_mcause", 1, 12'h342, 32'h2, 1, 0, 0);
      nxt(); chk("mix_mstatus", 1, 12'h300, 32'h1880, 1, 0, 0);
      nxt(); chk("mix_jump", 0, 0, 0, 1, 1, 32'h100);
      nxt(); chk("mix_irq_T", 0, 0, 0, 1, 0, 0);
      nxt(); irq = 1'b0;
      chk("mix_irq_mepc", 1, 12'h341, 32'h300, 1, 0, 0);
      nxt(); chk("mix_irq_mcause", 1, 12'h342, 32'h8000000B, 1, 0, 0);
      nxt(); chk("mix_irq_mstatus", 1, 12'h300, 32'h1880, 1, 0, 0);
      nxt(); chk("mix_irq_jump", 0, 0, 0, 1, 1, 32'h100);
      nxt(); chk("mix_idle", 0, 0, 0, 0, 0, 0);

      // reset during W_MCAUSE aborts the trap
      exc_req = 1'b1; exc_cause = 4'd11; exc_pc = 32'h80;
      chk("rst_T", 0, 0, 0, 1, 0, 0);
      nxt(); quiet();
      chk("rst_mepc", 1, 12'h341, 32'h80, 1, 0, 0);
      nxt(); rst_n = 1'b0;
      chk("rst_in_mcause", 0, 0, 0, 0, 0, 0);
      nxt(); rst_n = 1'b1;
      chk("rst_after1", 0, 0, 0, 0, 0, 0);
      nxt(); chk("rst_after2", 0, 0, 0, 0, 0, 0);
      nxt(); chk("rst_after3", 0, 0, 0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter: CSR_AW, 12, CSR address width.
REQ-002 Parameter: XLEN, 32, data and PC width.
REQ-003 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n_i  in  1  reset, synchronous, active-low.
REQ-005 exc_req_i  in  1  synchronous exception (ecall/ebreak/illegal) from the execute stage.
REQ-006 exc_cause_i  in  4  exception code.
REQ-007 exc_pc_i  in  XLEN  PC of the faulting instruction.
REQ-008 irq_i  in  1  machine external interrupt, level.
REQ-009 int_pc_i  in  XLEN  PC of the next unexecuted instruction, used as the resume PC for interrupts.
REQ-010 mret_i  in  1  MRET being executed.
REQ-011 mtvec_i / mepc_i / mstatus_i / mie_i  in  XLEN each  current CSR file contents.
REQ-012 ex_csr_we_i, ex_csr_waddr_i (CSR_AW), ex_csr_wdata_i (XLEN)  in  execute-stage CSR write request.
REQ-013 csr_we_o, csr_waddr_o (CSR_AW), csr_wdata_o (XLEN)  out  arbitrated CSR file write port.
REQ-014 hold_o  out  1  pipeline stall.
REQ-015 jump_o  out  1  one-cycle redirect strobe; jump_addr_o  out  XLEN  redirect target.

Function
REQ-016 The FSM SHALL have states IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, R_MSTATUS, JUMP.
REQ-017 In IDLE, the exe write port SHALL pass straight through to csr_*_o with zero latency.
REQ-018 In IDLE, the accept priority SHALL be exc_req_i > pending interrupt > mret_i.
REQ-019 An interrupt is pending when irq_i & mstatus_i[3] & mie_i[11]; it SHALL be deferred (not accepted) in any cycle where ex_csr_we_i=1.
REQ-020 On exception accept (cycle T), the exe write SHALL be suppressed (csr_we_o=0), and exc_pc_i, the cause {0,27'b0,exc_cause_i} and is_irq=0 SHALL be latched.
REQ-021 On interrupt accept, int_pc_i, the cause {1,31'd11} and is_irq=1 SHALL be latched.
REQ-022 hold_o SHALL be 1 combinationally in cycle T and in every non-IDLE state.
REQ-023 Trap sequence: W_MEPC (T+1) writes 0x341 with the latched PC; W_MCAUSE (T+2) writes 0x342 with the latched cause; W_MSTATUS (T+3) writes 0x300; JUMP (T+4).
REQ-024 Trap mstatus write value: MPIE[7] <- MIE[3], MIE <- 0, MPP[12:11] <- 2'b11, all other bits from mstatus_i.
REQ-025 On MRET accept, the FSM SHALL go to R_MSTATUS (T+1), writing 0x300 with MIE <- MPIE, MPIE <- 1, MPP <- 2'b11; then JUMP (T+2).
REQ-026 In JUMP: jump_o=1 for exactly one cycle, hold_o=1, csr_we_o=0, then the FSM returns to IDLE.
REQ-027 Trap jump target: {mtvec_i[31:2],2'b00}.
REQ-028 MRET jump target: mepc_i sampled in JUMP.
REQ-029 Outside IDLE, exc_req_i, irq_i, mret_i and ex_csr_we_i SHALL be ignored; a held irq_i is re-evaluated on the return to IDLE.
REQ-030 jump_addr_o SHALL be 0 whenever jump_o=0.
REQ-031 csr_waddr_o and csr_wdata_o SHALL be 0 whenever csr_we_o=0.

Reset
REQ-032 While rst_n_i=0 at a clock edge: state <- IDLE; latched PC, cause and is_irq <- 0.
REQ-033 While rst_n_i=0, all outputs SHALL be 0.
REQ-034 Reset mid-sequence SHALL abort it with no further CSR writes or jump.

Configuration
REQ-035 The macro is TRAP_VECTORED_EN.
REQ-036 With TRAP_VECTORED_EN defined, when mtvec_i[1:0]==2'b01 and is_irq=1, the trap target SHALL be base + 4*cause[30:0].
REQ-037 Without TRAP_VECTORED_EN, the target SHALL always be the base, and mtvec_i[1:0] SHALL be ignored.

Verification
REQ-038 Exception: exc_req_i=1, cause=11, pc=0x80 -> writes 0x341=0x80, 0x342=0xB, 0x300 with MIE=0; then jump_o to 0x100 at T+4, with mtvec=0x100 and mstatus=0x8.
REQ-039 Interrupt, vectored: irq_i=1, mstatus=0x8, mie=0x800, mtvec=0x101, int_pc=0x44 -> mepc=0x44, mcause=0x8000000B, jump to 0x12C.
REQ-040 Interrupt, direct: same stimulus with the macro undefined -> jump to 0x100.
REQ-041 MRET: mret_i=1, mstatus=0x1880, mepc=0x84 -> 0x300 written as 0x1888, jump to 0x84 at T+2.
REQ-042 Simultaneous exception, irq and exe CSR write -> exception path taken, exe write dropped, irq taken after the return to IDLE.
REQ-043 rst_n_i=0 during W_MCAUSE -> no 0x300 write, no jump_o, hold_o=0 on the next cycle.
